// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates an instruction-fetch port and a data load/store port
//             onto one shared single-port 256x8 synchronous RAM. Data wins
//             contention until it has taken STARVE_LIMIT grants in a row while
//             fetch was waiting; the next contended grant then goes to fetch.
//  Ports    : clk, reset            - clock, async active-high reset
//             if_req/if_addr        - fetch request and address
//             if_ack/if_rdata       - fetch completion and instruction byte
//             d_req/d_we/d_addr/
//             d_wdata               - data request (load or store)
//             d_ack/d_rdata         - data completion and load byte
//             ram_addr/ram_we/
//             ram_wdata/ram_rdata   - shared RAM interface
//             busy                  - transaction in progress
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       if_req,
    input  logic [7:0] if_addr,
    output logic       if_ack,
    output logic [7:0] if_rdata,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_ack,
    output logic [7:0] d_rdata,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       busy
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] c_LIMIT = STREAK_W'(STARVE_LIMIT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_READ   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]          state_q,    state_d;
    logic                owner_q,    owner_d;     // 0 = fetch, 1 = data
    logic [STREAK_W-1:0] streak_q,   streak_d;
    logic [7:0]          addr_q,     addr_d;
    logic                we_q,       we_d;
    logic [7:0]          wdata_q,    wdata_d;
    logic [7:0]          if_rdata_q, if_rdata_d;
    logic [7:0]          d_rdata_q,  d_rdata_d;

    // Data takes a contended slot unless fetch has already waited out a full streak.
    logic w_grant_data;
    assign w_grant_data = d_req && (!if_req || (streak_q != c_LIMIT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= c_IDLE;
            owner_q    <= 1'b0;
            streak_q   <= '0;
            addr_q     <= 8'h00;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            if_rdata_q <= 8'h00;
            d_rdata_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            c_IDLE: begin
                if (if_req || d_req) begin
                    state_d = c_ACCESS;
                    owner_d = w_grant_data;
                    if (w_grant_data) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        // Streak only grows while fetch is actually being held off.
                        if (if_req) begin
                            if (streak_q != c_LIMIT) begin
                                streak_d = streak_q + STREAK_W'(1);
                            end
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = 8'h00;
                        streak_d = '0;
                    end
                end
            end
            c_ACCESS: begin
                state_d = we_q ? c_DONE : c_READ;
            end
            c_READ: begin
                // RAM data for the address presented in ACCESS is valid now.
                state_d = c_DONE;
                if (owner_q) begin
                    d_rdata_d = ram_rdata;
                end else begin
                    if_rdata_d = ram_rdata;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != c_IDLE);
        ram_we    = (state_q == c_ACCESS) && we_q;
        if_ack    = (state_q == c_DONE) && !owner_q;
        d_ack     = (state_q == c_DONE) &&  owner_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter with a behavioural RAM,
//             a shadow-memory reference model and an ack-driven scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 3;

    logic       clk;
    logic       reset;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_ack;
    logic [7:0] if_rdata;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [7:0] mem [256];
    logic       mem_init;

    function automatic logic [7:0] init_val(input int i);
        if (i == 8'h10) return 8'hA5;
        if (i == 8'h20) return 8'h00;
        return 8'((i * 37) + 11);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            ram_rdata <= 8'h00;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic       we;
        logic [7:0] data;
    } dexp_t;

    logic [7:0] shadow [256];
    logic [7:0] exp_f [$];
    dexp_t      exp_d [$];
    bit         order [$];      // 1 = data ack, 0 = fetch ack
    int         we_cnt;
    int         n_cmp;
    int         n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !mem_init) begin
            if (ram_we) we_cnt++;
            if (if_ack || d_ack) chk("ack_exclusive", {31'b0, if_ack && d_ack}, 32'd0);
            if (if_ack) begin
                order.push_back(1'b0);
                if (exp_f.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_if_ack: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("if_rdata", {24'b0, if_rdata}, {24'b0, exp_f.pop_front()});
                end
            end
            if (d_ack) begin
                order.push_back(1'b1);
                if (exp_d.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_d_ack: got 1 expected 0 at %0t", $time);
                end else begin
                    dexp_t e;
                    e = exp_d.pop_front();
                    if (!e.we) chk("d_rdata", {24'b0, d_rdata}, {24'b0, e.data});
                end
            end
        end
    end

    // ---------------- requester tasks (start and end at posedge+1) ----------------
    task automatic fetch_txn(input logic [7:0] a, output int lat);
        if_req  = 1'b1;
        if_addr = a;
        exp_f.push_back(shadow[a]);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_ack && lat < 60);
        if (!if_ack) begin
            n_cmp++; n_err++;
            $display("FAIL if_ack_timeout: got none expected ack within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic data_txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                            output int lat);
        dexp_t e;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        e.we    = we;
        e.data  = shadow[a];
        exp_d.push_back(e);
        if (we) shadow[a] = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ack && lat < 60);
        if (!d_ack) begin
            n_cmp++; n_err++;
            $display("FAIL d_ack_timeout: got none expected ack within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // Fetch addresses come from 0x00-0x3F / 0xC0-0xFF, data from 0x40-0xBF,
    // so fetch expectations never depend on data ordering.
    task automatic fetch_agent(input int n, input int maxgap);
        int lat;
        int g;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            fetch_txn(r[7] ? {2'b11, r[5:0]} : {2'b00, r[5:0]}, lat);
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (g > 0) begin
                if_req = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic data_agent(input int n, input int maxgap);
        int lat;
        int g;
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = 8'h40 + 8'($urandom_range(0, 127));
            data_txn(1'($urandom_range(0, 1)), a, 8'($urandom), lat);
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            if (g > 0) begin
                d_req = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
        end
        d_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int base;
        n_cmp    = 0;
        n_err    = 0;
        we_cnt   = 0;
        reset    = 1'b1;
        mem_init = 1'b1;
        if_req   = 1'b0;
        if_addr  = 8'h00;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 8'h00;
        d_wdata  = 8'h00;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      {31'b0, busy},   32'd0);
        chk("rst_if_ack",    {31'b0, if_ack}, 32'd0);
        chk("rst_d_ack",     {31'b0, d_ack},  32'd0);
        chk("rst_ram_we",    {31'b0, ram_we}, 32'd0);
        chk("rst_ram_addr",  {24'b0, ram_addr},  32'd0);
        chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
        chk("rst_if_rdata",  {24'b0, if_rdata},  32'd0);
        chk("rst_d_rdata",   {24'b0, d_rdata},   32'd0);
        mem_init = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;

        // Fetch only from 0x10
        base = we_cnt;
        fetch_txn(8'h10, lat);
        if_req = 1'b0;
        chk("fetch_latency", lat, 32'd4);
        chk("fetch_no_write", we_cnt - base, 32'd0);
        chk("fetch_rdata_hold", {24'b0, if_rdata}, 32'hA5);
        @(posedge clk); #1;

        // Store then load at 0x80
        data_txn(1'b1, 8'h80, 8'h3C, lat);
        d_req = 1'b0;
        chk("store_latency", lat, 32'd3);
        chk("store_mem", {24'b0, mem[8'h80]}, 32'h3C);
        @(posedge clk); #1;
        data_txn(1'b0, 8'h80, 8'h00, lat);
        d_req = 1'b0;
        chk("load_latency", lat, 32'd4);
        chk("load_rdata_hold", {24'b0, d_rdata}, 32'h3C);
        @(posedge clk); #1;

        // Back-to-back fetches across the address boundary
        fetch_txn(8'hFE, lat);
        chk("b2b_lat_FE", lat, 32'd4);
        fetch_txn(8'hFF, lat);
        chk("b2b_lat_FF", lat, 32'd4);
        fetch_txn(8'h00, lat);
        chk("b2b_lat_00", lat, 32'd4);
        if_req = 1'b0;
        @(posedge clk); #1;

        // Both continuously requesting: data gets STARVE_LIMIT slots, then fetch
        base = order.size();
        fork
            fetch_agent(2, 0);
            data_agent(2 * STARVE_LIMIT, 0);
        join
        chk("starve_count", order.size() - base, 2 * (STARVE_LIMIT + 1));
        for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
            if (base + i < order.size())
                chk("grant_order", {31'b0, order[base + i]},
                    (i % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;

        // Random traffic on both ports
        fork
            fetch_agent(30, 3);
            data_agent(30, 3);
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset in ACCESS of a store to 0x20
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 8'h20;
        d_wdata = 8'h5A;
        @(posedge clk);
        #2;
        chk("access_ram_we", {31'b0, ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy",     {31'b0, busy},   32'd0);
        chk("arst_ram_we",   {31'b0, ram_we}, 32'd0);
        chk("arst_d_ack",    {31'b0, d_ack},  32'd0);
        chk("arst_ram_addr", {24'b0, ram_addr}, 32'd0);
        chk("arst_d_rdata",  {24'b0, d_rdata},  32'd0);
        chk("arst_if_rdata", {24'b0, if_rdata}, 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_no_commit", {24'b0, mem[8'h20]}, 32'h00);
        @(posedge clk); #1;
        fetch_txn(8'h10, lat);
        if_req = 1'b0;
        chk("post_rst_fetch_lat", lat, 32'd4);
        data_txn(1'b0, 8'h20, 8'h00, lat);
        d_req = 1'b0;
        chk("post_rst_load_lat", lat, 32'd4);

        repeat (4) @(posedge clk);
        #1;
        chk("exp_f_drained", exp_f.size(), 32'd0);
        chk("exp_d_drained", exp_d.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
